// File: rtl/pipe_pkg.sv
// Shared types for the forwarding scoreboard: the per-stage entry and
// the forward-select width helper.
package pipe_pkg;

  localparam int DEST_W = 5;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [DEST_W-1:0] dest;
  } stage_t;

  // Select encodes 0 = register file, k+1 = stage k, so NSTG+1 codes.
  function automatic int sel_width(input int nstg);
    return $clog2(nstg + 1);
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide busy counter: reloads on every accepted MD issue and
// counts down to zero; busy while non-zero.
module md_busy_ctr #(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_busy
);

  localparam int CW = $clog2(MD_LAT + 1);

  logic [CW-1:0] r_cnt;

  // Reload wins over decrement so back-to-back MD ops restart the window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_cnt <= '0;
    else if (i_load)         r_cnt <= CW'(MD_LAT);
    else if (r_cnt != '0)    r_cnt <= r_cnt - CW'(1);
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks writers in the stages after D, picks the
// youngest matching producer per source port and stalls D when that
// producer cannot forward yet or when hi/lo is read during an MD op.
module fwd_scoreboard
  import pipe_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int NSTG   = 3,
  parameter int AW     = 5,
  parameter int LD_RDY = 2,
  parameter int MD_LAT = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NSTG-1:0]                       stall_i,
  input  logic [NSTG-1:0]                       flush_i,
  input  logic                                  issue_valid_i,
  input  logic                                  issue_we_i,
  input  logic [AW-1:0]                         issue_dest_i,
  input  logic                                  issue_load_i,
  input  logic                                  issue_md_i,
  input  logic                                  hilo_acc_i,
  input  logic [NSRC*AW-1:0]                    src_addr_i,
  input  logic [NSRC-1:0]                       src_used_i,
  output logic [NSRC*sel_width(NSTG)-1:0]       fwd_sel_o,
  output logic                                  stall_o,
  output logic                                  md_busy_o
);

  localparam int SELW = sel_width(NSTG);

  stage_t [NSTG-1:0] w_stg;
  stage_t            w_issue;
  logic   [NSTG-1:0] w_rdy;
  logic   [NSRC-1:0] w_nrdy;
  logic              w_md_busy;
  logic              w_md_acc;

  // A stalled D enters stage 0 as a bubble.
  assign w_issue = '{valid: issue_valid_i & ~stall_o,
                     we:    issue_we_i,
                     load:  issue_load_i,
                     dest:  issue_dest_i};

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam logic RDY_LD = (k >= LD_RDY);
    localparam logic RDY_AL = (k >= 1);
    stage_t r_q;
    stage_t w_d;

    if (k == 0) begin : g_head
      assign w_d = w_issue;
    end else begin : g_body
      assign w_d = w_stg[k-1];
    end

    // Flush beats stall; stall holds the entry in place.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)           r_q <= '0;
      else if (flush_i[k])  r_q <= '0;
      else if (!stall_i[k]) r_q <= w_d;
    end

    assign w_stg[k] = r_q;
    assign w_rdy[k] = w_stg[k].load ? RDY_LD : RDY_AL;
  end

  for (genvar j = 0; j < NSRC; j++) begin : g_port
    logic [AW-1:0]   w_addr;
    logic [NSTG-1:0] w_hit;
    logic [SELW-1:0] w_sel;
    logic            w_nr;

    assign w_addr = src_addr_i[j*AW +: AW];

    for (genvar k = 0; k < NSTG; k++) begin : g_hit
      assign w_hit[k] = w_stg[k].valid & w_stg[k].we & (w_stg[k].dest == w_addr) &
                        (w_addr != '0) & src_used_i[j];
    end

    // Scan oldest to youngest so the youngest (lowest k) match wins.
    always_comb begin
      w_sel = '0;
      w_nr  = 1'b0;
      for (int k = NSTG - 1; k >= 0; k--) begin
        if (w_hit[k]) begin
          w_sel = SELW'(k + 1);
          w_nr  = ~w_rdy[k];
        end
      end
    end

    assign fwd_sel_o[j*SELW +: SELW] = w_sel;
    assign w_nrdy[j]                 = w_nr;
  end

  assign stall_o   = (|w_nrdy) | (hilo_acc_i & w_md_busy);
  assign w_md_acc  = issue_valid_i & issue_md_i & ~stall_o & ~stall_i[0] & ~flush_i[0];
  assign md_busy_o = w_md_busy;

  md_busy_ctr #(.MD_LAT(MD_LAT)) u_md (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_md_acc),
    .o_busy (w_md_busy)
  );

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter NSRC, default 2, number of D-stage source operand ports.
REQ-002 Parameter NSTG, default 3, number of tracked stages after D (stage 0 = E, last = W).
REQ-003 Parameter AW, default 5, register address width.
REQ-004 Parameter LD_RDY, default 2, first stage index at which a load result is forwardable.
REQ-005 Parameter MD_LAT, default 32, multiply/divide busy cycles.
REQ-006 Localparam SELW = clog2(NSTG+1), forward-select width.
REQ-007 Clocking: one clock; reset is asynchronous and active-low (ports clk, reset).
REQ-008 clk  in  1  rising-edge clock.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 stall_i  in  NSTG  per-stage hold; bit k holds stage k.
REQ-011 flush_i  in  NSTG  per-stage clear; bit k bubbles stage k.
REQ-012 issue_valid_i  in  1  D instruction presented for entry to stage 0.
REQ-013 issue_we_i  in  1  issuing instruction writes a register.
REQ-014 issue_dest_i  in  AW  destination register.
REQ-015 issue_load_i  in  1  result comes from memory.
REQ-016 issue_md_i  in  1  issuing instruction starts a multiply/divide.
REQ-017 hilo_acc_i  in  1  D instruction accesses hi/lo.
REQ-018 src_addr_i  in  NSRC*AW  source register addresses, port j at [j*AW +: AW].
REQ-019 src_used_i  in  NSRC  port j is read.
REQ-020 fwd_sel_o  out  NSRC*SELW  per port: 0 = register file, k+1 = forward from stage k.
REQ-021 stall_o  out  1  D must hold.
REQ-022 md_busy_o  out  1  multiply/divide in progress (registered).

Function
REQ-023 Per stage k: valid, we, load, dest.
  - Stage 0 captures the issue_* fields when ~stall_i[0].
  - Stage k>0 captures stage k-1 when ~stall_i[k].
REQ-024 Stage 0 captures a bubble when issue_valid_i=0 or stall_o=1.
REQ-025 flush_i[k]=1 clears valid at stage k next edge; flush_i[k] overrides stall_i[k].
REQ-026 Stage k matches port j when all of the following hold:
  - valid
  - we
  - dest = src_addr_j
  - src_addr_j != 0
  - src_used_i[j] = 1
REQ-027 fwd_sel for port j = (lowest matching k)+1; 0 when no stage matches.
REQ-028 The lowest matching stage is ready when:
  - k >= 1 (non-load), or
  - k >= LD_RDY (load).
REQ-029 stall_o = (any port's lowest match not ready) OR (hilo_acc_i AND md_busy_o); combinational.
REQ-030 A result leaving the last stage is in the register file; no forwarding beyond stage NSTG-1.
REQ-031 MD counter:
  - Loads MD_LAT when issue_md_i is accepted into stage 0 (valid, no stall_o, no stall_i[0], no flush_i[0]).
  - Otherwise decrements to 0.
  - md_busy_o = counter != 0.
REQ-032 A new MD acceptance while busy reloads MD_LAT; a flush after acceptance does not cancel the counter.
REQ-033 stall_i[k]=1 with stall_i[k-1]=0 is illegal input; behaviour is undefined and the bench flags it.

Reset
REQ-034 reset low clears all stage valid bits and the MD counter asynchronously.
REQ-035 During and after reset: md_busy_o=0; fwd_sel_o=0 and stall_o=0 while src_used_i=0 and hilo_acc_i=0.

Structure
REQ-036 Package pipe_pkg holds the stage-entry struct (valid, we, load, dest) and the SELW function.
REQ-037 Sub-module md_busy_ctr (MD_LAT counter) is instantiated once; stage array and match logic are generate loops.

Verification
REQ-038 Scenario 1: add r3 issued, next D reads r3 on port 0 -> fwd_sel0=1 on the cycle r3 is in stage 0, stall_o=1 one cycle, then fwd_sel0=2, stall_o=0.
REQ-039 Scenario 2: lw r4, then D reads r4 on port 1 (LD_RDY=2) -> stall_o=1 for 2 cycles, then fwd_sel1=3.
REQ-040 Scenario 3: r5 in stages 1 and 2 (two writers), D reads r5 -> fwd_sel=2 (youngest).
REQ-041 Scenario 4: src_addr=0, stage 1 dest=0 with we=1 -> fwd_sel=0, stall_o=0.
REQ-042 Scenario 5: issue_md accepted, hilo_acc_i=1 next cycle -> md_busy_o and stall_o high for 32 cycles, low on cycle 33.
REQ-043 Scenario 6: stall_i[1]=flush_i[1]=1 with r6 in stage 1 -> r6 gone next cycle. Assert reset mid-MD -> md_busy_o=0 immediately.
